// File: rtl/uart_dump_ctrl.sv
// Histogram RAM readout scheduler: walks every bin, hands (address, count) pairs to the
// UART frame transmitter, optionally clears each bin, and generates the shared baud tick.
module uart_dump_ctrl #(
  parameter int WIDTH_DATA    = 16,
  parameter int LENGTH_ADDR   = 10,
  parameter int CLK_DIV       = 10417,
  parameter int TIMEOUT_TICKS = 64,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dump_req,
  input  logic                   acq_busy,
  output logic                   acq_en,
  output logic [LENGTH_ADDR-1:0] ram_addr,
  output logic                   ram_rd,
  input  logic [WIDTH_DATA-1:0]  ram_rdata,
  output logic                   ram_we,
  output logic [WIDTH_DATA-1:0]  ram_wdata,
  output logic                   tx_en,
  output logic                   tx_start,
  output logic [LENGTH_ADDR-1:0] tx_addr,
  output logic [WIDTH_DATA-1:0]  tx_word,
  input  logic                   tx_done,
  output logic                   dump_busy,
  output logic                   dump_done,
  output logic                   dump_err
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [CNT_W-1:0]       CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);
  localparam logic [LENGTH_ADDR-1:0] BIN_LAST = {LENGTH_ADDR{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nx_s;
  logic [TMO_W-1:0]       tmo_r;
  logic [TMO_W-1:0]       tmo_nx_s;
  logic [LENGTH_ADDR-1:0] bin_r;
  logic [LENGTH_ADDR-1:0] bin_nx_s;
  logic                   dump_err_nx_s;
  logic                   dump_done_nx_s;

  logic                   acq_en_r;
  logic [LENGTH_ADDR-1:0] ram_addr_r;
  logic                   ram_rd_r;
  logic                   ram_we_r;
  logic                   tx_en_r;
  logic                   tx_start_r;
  logic [LENGTH_ADDR-1:0] tx_addr_r;
  logic [WIDTH_DATA-1:0]  tx_word_r;
  logic                   dump_busy_r;
  logic                   dump_done_r;
  logic                   dump_err_r;

  // Baud divider next value: free-running 0 .. CLK_DIV-1 regardless of FSM state.
  always_comb begin
    cnt_nx_s = cnt_r;
    if (cnt_r == CNT_MAX) begin
      cnt_nx_s = {CNT_W{1'b0}};
    end else begin
      cnt_nx_s = cnt_r + CNT_W'(1);
    end
  end

  // Dump sequencer next-state and next-value logic.
  always_comb begin
    state_nx_s     = state_r;
    bin_nx_s       = bin_r;
    tmo_nx_s       = tmo_r;
    dump_err_nx_s  = dump_err_r;
    dump_done_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dump_req) begin
          state_nx_s    = ST_DRAIN;
          bin_nx_s      = {LENGTH_ADDR{1'b0}};
          dump_err_nx_s = 1'b0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!acq_busy) begin
          state_nx_s = ST_READ;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_READ: begin
        state_nx_s = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nx_s = ST_SEND;
        tmo_nx_s   = {TMO_W{1'b0}};
      end
      ST_SEND: begin
        // tx_done takes priority over a timeout expiring in the same cycle.
        if (tx_done) begin
          state_nx_s = ST_NEXT;
        end else if (tx_en_r) begin
          if (tmo_r == TMO_LAST) begin
            state_nx_s    = ST_DONE;
            dump_err_nx_s = 1'b1;
          end else begin
            tmo_nx_s = tmo_r + TMO_W'(1);
          end
        end else begin
          state_nx_s = ST_SEND;
        end
      end
      ST_NEXT: begin
        if (bin_r == BIN_LAST) begin
          state_nx_s     = ST_DONE;
          dump_done_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_READ;
          bin_nx_s   = bin_r + LENGTH_ADDR'(1);
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs (outputs are derived from the next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      bin_r       <= {LENGTH_ADDR{1'b0}};
      acq_en_r    <= 1'b1;
      ram_addr_r  <= {LENGTH_ADDR{1'b0}};
      ram_rd_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      tx_en_r     <= 1'b0;
      tx_start_r  <= 1'b0;
      tx_addr_r   <= {LENGTH_ADDR{1'b0}};
      tx_word_r   <= {WIDTH_DATA{1'b0}};
      dump_busy_r <= 1'b0;
      dump_done_r <= 1'b0;
      dump_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      tmo_r       <= tmo_nx_s;
      bin_r       <= bin_nx_s;
      acq_en_r    <= (state_nx_s == ST_IDLE);
      ram_addr_r  <= bin_nx_s;
      ram_rd_r    <= (state_nx_s == ST_READ);
      ram_we_r    <= CLEAR_ON_READ && (state_nx_s == ST_CAPTURE);
      tx_en_r     <= (cnt_nx_s == CNT_MAX);
      tx_start_r  <= (state_r == ST_CAPTURE);
      dump_busy_r <= (state_nx_s != ST_IDLE);
      dump_done_r <= dump_done_nx_s;
      dump_err_r  <= dump_err_nx_s;
      // Read data arrives in CAPTURE and stays frozen for the whole frame.
      if (state_r == ST_CAPTURE) begin
        tx_addr_r <= bin_r;
        tx_word_r <= ram_rdata;
      end else begin
        tx_addr_r <= tx_addr_r;
        tx_word_r <= tx_word_r;
      end
    end
  end

  assign acq_en    = acq_en_r;
  assign ram_addr  = ram_addr_r;
  assign ram_rd    = ram_rd_r;
  assign ram_we    = ram_we_r;
  assign ram_wdata = {WIDTH_DATA{1'b0}};
  assign tx_en     = tx_en_r;
  assign tx_start  = tx_start_r;
  assign tx_addr   = tx_addr_r;
  assign tx_word   = tx_word_r;
  assign dump_busy = dump_busy_r;
  assign dump_done = dump_done_r;
  assign dump_err  = dump_err_r;

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Bench for uart_dump_ctrl: two instances (clear-on-read on/off) with a RAM model,
// a randomized-latency transmitter model, and a frame/event log compared to a snapshot model.
module tb_uart_dump_ctrl;

  localparam int NB = 8;
  localparam int LOGN = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic        dump_req [2];
  logic        acq_busy [2];
  logic        acq_en [2];
  logic [2:0]  ram_addr [2];
  logic        ram_rd [2];
  logic [15:0] ram_rdata [2];
  logic        ram_we [2];
  logic [15:0] ram_wdata [2];
  logic        tx_en [2];
  logic        tx_start [2];
  logic [2:0]  tx_addr [2];
  logic [15:0] tx_word [2];
  logic        tx_done [2];
  logic        dump_busy [2];
  logic        dump_done [2];
  logic        dump_err [2];

  logic [15:0] mem [2][NB];
  logic [15:0] ld_val [2][NB];
  logic        ld_req [2];
  int          hang [2];
  int          fixed_dly [2];
  int          fn [2];
  logic [2:0]  fa [2][LOGN];
  logic [15:0] fw [2][LOGN];
  int          dd_cnt [2];
  int          we_cnt [2];
  int          tick_cnt [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    int pend;
    int dly;

    uart_dump_ctrl #(
      .WIDTH_DATA(16), .LENGTH_ADDR(3), .CLK_DIV(4), .TIMEOUT_TICKS(8),
      .CLEAR_ON_READ((g == 0) ? 1'b1 : 1'b0)
    ) dut (
      .clk(clk), .rst_n(rst_n), .dump_req(dump_req[g]), .acq_busy(acq_busy[g]),
      .acq_en(acq_en[g]), .ram_addr(ram_addr[g]), .ram_rd(ram_rd[g]),
      .ram_rdata(ram_rdata[g]), .ram_we(ram_we[g]), .ram_wdata(ram_wdata[g]),
      .tx_en(tx_en[g]), .tx_start(tx_start[g]), .tx_addr(tx_addr[g]),
      .tx_word(tx_word[g]), .tx_done(tx_done[g]), .dump_busy(dump_busy[g]),
      .dump_done(dump_done[g]), .dump_err(dump_err[g])
    );

    // RAM with one-cycle read latency; ld_req preloads the contents.
    always @(posedge clk) begin
      if (ld_req[g]) begin
        for (int k = 0; k < NB; k++) mem[g][k] = ld_val[g][k];
      end else begin
        if (ram_rd[g]) ram_rdata[g] <= mem[g][ram_addr[g]];
        if (ram_we[g]) begin
          mem[g][ram_addr[g]] = ram_wdata[g];
          we_cnt[g] = we_cnt[g] + 1;
        end
      end
    end

    // Transmitter: tx_done a random number of cycles after tx_start, never for the hang bin.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tx_done[g] <= 1'b0;
        pend = 0;
        dly = 0;
      end else begin
        tx_done[g] <= 1'b0;
        if (pend != 0) begin
          if (dly <= 1) begin
            tx_done[g] <= 1'b1;
            pend = 0;
          end else begin
            dly = dly - 1;
          end
        end
        if (tx_start[g] && (int'(tx_addr[g]) != hang[g])) begin
          pend = 1;
          dly = (fixed_dly[g] > 0) ? fixed_dly[g] : int'($urandom_range(20, 1));
        end
      end
    end

    // Event log: frames, completions, and baud ticks seen since the latest frame start.
    always @(posedge clk) begin
      if (rst_n) begin
        if (tx_start[g]) begin
          if (fn[g] < LOGN) begin
            fa[g][fn[g]] = tx_addr[g];
            fw[g][fn[g]] = tx_word[g];
          end
          fn[g] = fn[g] + 1;
          tick_cnt[g] = tx_en[g] ? 1 : 0;
        end else if (tx_en[g] && !dump_err[g] && dump_busy[g]) begin
          tick_cnt[g] = tick_cnt[g] + 1;
        end
        if (dump_done[g]) dd_cnt[g] = dd_cnt[g] + 1;
      end
    end
  end

  task automatic load(input int g, input int mode);
    for (int k = 0; k < NB; k++)
      ld_val[g][k] = (mode == 0) ? 16'(16'h1000 + k) : 16'($urandom);
    ld_req[g] = 1'b1;
    @(negedge clk);
    ld_req[g] = 1'b0;
  endtask

  task automatic start_dump(input int g);
    dump_req[g] = 1'b1;
    @(negedge clk);
    dump_req[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, output bit to);
    to = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!dump_busy[g]) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [45:0] obs;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      obs = {acq_en[g], ram_addr[g], ram_rd[g], ram_we[g], ram_wdata[g], tx_en[g], tx_start[g],
             tx_addr[g], tx_word[g], dump_busy[g], dump_done[g], dump_err[g]};
      total++;
      if (obs !== {1'b1, 45'd0}) begin
        bad++;
        $display("FAIL reset_outputs g=%0d got=%h want=%h", g, obs, {1'b1, 45'd0});
      end
    end
  endtask

  task automatic test_divider;
    logic exp_en;
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      #1;
      exp_en = ((c % 4) == 0);
      total++;
      if (tx_en[0] !== exp_en) begin
        bad++;
        $display("FAIL divider cycle=%0d got=%b want=%b", c, tx_en[0], exp_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_dump(input int g, input int mode);
    int f0, d0, w0;
    bit to;
    logic [15:0] exp_m;
    load(g, mode);
    f0 = fn[g]; d0 = dd_cnt[g]; w0 = we_cnt[g];
    start_dump(g);
    wait_idle(g, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL dump_timeout g=%0d got=busy want=idle", g); end
    total++;
    if (fn[g] - f0 !== NB) begin bad++; $display("FAIL frame_count g=%0d got=%0d want=%0d", g, fn[g] - f0, NB); end
    for (int k = 0; k < NB; k++) begin
      total++;
      if (fa[g][f0 + k] !== 3'(k) || fw[g][f0 + k] !== ld_val[g][k]) begin
        bad++;
        $display("FAIL frame g=%0d k=%0d got=(%0d,%h) want=(%0d,%h)", g, k, fa[g][f0 + k], fw[g][f0 + k], k, ld_val[g][k]);
      end
    end
    total++;
    if (dd_cnt[g] - d0 !== 1) begin bad++; $display("FAIL dump_done_count g=%0d got=%0d want=1", g, dd_cnt[g] - d0); end
    total++;
    if ({acq_en[g], dump_err[g]} !== 2'b10) begin bad++; $display("FAIL end_flags g=%0d got=%b want=10", g, {acq_en[g], dump_err[g]}); end
    for (int k = 0; k < NB; k++) begin
      exp_m = (g == 0) ? 16'h0000 : ld_val[g][k];
      total++;
      if (mem[g][k] !== exp_m) begin bad++; $display("FAIL ram_after g=%0d k=%0d got=%h want=%h", g, k, mem[g][k], exp_m); end
    end
    if (g == 1) begin
      total++;
      if (we_cnt[g] - w0 !== 0) begin bad++; $display("FAIL no_clear_we g=%0d got=%0d want=0", g, we_cnt[g] - w0); end
    end
  endtask

  task automatic test_drain;
    int d0;
    bit to;
    load(0, 1);
    d0 = dd_cnt[0];
    acq_busy[0] = 1'b1;
    start_dump(0);
    total++;
    if (acq_en[0] !== 1'b0) begin bad++; $display("FAIL drain_acq_en got=%b want=0", acq_en[0]); end
    for (int c = 0; c < 9; c++) begin
      total++;
      if (ram_rd[0] !== 1'b0) begin bad++; $display("FAIL drain_early_rd cycle=%0d got=%b want=0", c, ram_rd[0]); end
      @(negedge clk);
    end
    acq_busy[0] = 1'b0;
    @(negedge clk);
    total++;
    if (ram_rd[0] !== 1'b1 || ram_addr[0] !== 3'd0) begin
      bad++; $display("FAIL drain_first_rd got=(%b,%0d) want=(1,0)", ram_rd[0], ram_addr[0]);
    end
    wait_idle(0, to);
    total++;
    if (to !== 1'b0 || dd_cnt[0] - d0 !== 1) begin bad++; $display("FAIL drain_complete got=%0d want=1", dd_cnt[0] - d0); end
  endtask

  task automatic test_timeout;
    int f0, d0;
    bit to;
    logic [15:0] exp_m;
    load(0, 1);
    hang[0] = 2;
    f0 = fn[0]; d0 = dd_cnt[0];
    start_dump(0);
    wait_idle(0, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL tmo_idle got=busy want=idle"); end
    total++;
    if ({dump_err[0], acq_en[0], dump_busy[0]} !== 3'b110) begin
      bad++; $display("FAIL tmo_flags got=%b want=110", {dump_err[0], acq_en[0], dump_busy[0]});
    end
    total++;
    if (dd_cnt[0] - d0 !== 0) begin bad++; $display("FAIL tmo_no_done got=%0d want=0", dd_cnt[0] - d0); end
    total++;
    if (fn[0] - f0 !== 3) begin bad++; $display("FAIL tmo_frames got=%0d want=3", fn[0] - f0); end
    total++;
    if (tick_cnt[0] !== 8) begin bad++; $display("FAIL tmo_ticks got=%0d want=8", tick_cnt[0]); end
    for (int k = 0; k < NB; k++) begin
      exp_m = (k <= 2) ? 16'h0000 : ld_val[0][k];
      total++;
      if (mem[0][k] !== exp_m) begin bad++; $display("FAIL tmo_ram k=%0d got=%h want=%h", k, mem[0][k], exp_m); end
    end
    hang[0] = -1;
    d0 = dd_cnt[0];
    start_dump(0);
    total++;
    if (dump_err[0] !== 1'b0) begin bad++; $display("FAIL tmo_err_clear got=%b want=0", dump_err[0]); end
    wait_idle(0, to);
    total++;
    if (to !== 1'b0 || dd_cnt[0] - d0 !== 1 || dump_err[0] !== 1'b0) begin
      bad++; $display("FAIL tmo_recover got=%0d,%b want=1,0", dd_cnt[0] - d0, dump_err[0]);
    end
  endtask

  task automatic test_back_to_back;
    int f0, d0, n;
    bit to;
    load(0, 1);
    f0 = fn[0]; d0 = dd_cnt[0];
    start_dump(0);
    n = 0;
    while (fn[0] - f0 < 3 && n < 1000) begin @(negedge clk); n++; end
    start_dump(0);
    wait_idle(0, to);
    total++;
    if (to !== 1'b0 || fn[0] - f0 !== NB || dd_cnt[0] - d0 !== 1) begin
      bad++; $display("FAIL ignore_req got=frames %0d done %0d want=frames 8 done 1", fn[0] - f0, dd_cnt[0] - d0);
    end
    for (int k = 0; k < NB; k++) begin
      total++;
      if (fa[0][f0 + k] !== 3'(k) || fw[0][f0 + k] !== ld_val[0][k]) begin
        bad++; $display("FAIL ignore_frame k=%0d got=(%0d,%h) want=(%0d,%h)", k, fa[0][f0 + k], fw[0][f0 + k], k, ld_val[0][k]);
      end
    end
  endtask

  task automatic test_reset_mid_dump;
    int f0, d0, n;
    logic [45:0] obs;
    logic [15:0] exp_m;
    load(0, 1);
    fixed_dly[0] = 20;
    f0 = fn[0]; d0 = dd_cnt[0];
    start_dump(0);
    n = 0;
    while (fn[0] - f0 < 4 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    total++;
    if (fn[0] - f0 !== 4 || tx_addr[0] !== 3'd3 || dump_busy[0] !== 1'b1) begin
      bad++; $display("FAIL rst_setup got=frames %0d addr %0d want=frames 4 addr 3", fn[0] - f0, tx_addr[0]);
    end
    rst_n = 1'b0;
    #1;
    obs = {acq_en[0], ram_addr[0], ram_rd[0], ram_we[0], ram_wdata[0], tx_en[0], tx_start[0],
           tx_addr[0], tx_word[0], dump_busy[0], dump_done[0], dump_err[0]};
    total++;
    if (obs !== {1'b1, 45'd0}) begin bad++; $display("FAIL rst_mid_outputs got=%h want=%h", obs, {1'b1, 45'd0}); end
    @(negedge clk);
    rst_n = 1'b1;
    fixed_dly[0] = 0;
    repeat (60) @(negedge clk);
    total++;
    if (dd_cnt[0] - d0 !== 0 || dump_busy[0] !== 1'b0 || acq_en[0] !== 1'b1) begin
      bad++; $display("FAIL rst_mid_state got=done %0d busy %b want=done 0 busy 0", dd_cnt[0] - d0, dump_busy[0]);
    end
    for (int k = 0; k < NB; k++) begin
      exp_m = (k <= 3) ? 16'h0000 : ld_val[0][k];
      total++;
      if (mem[0][k] !== exp_m) begin bad++; $display("FAIL rst_mid_ram k=%0d got=%h want=%h", k, mem[0][k], exp_m); end
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      dump_req[g] = 1'b0;
      acq_busy[g] = 1'b0;
      ld_req[g] = 1'b0;
      hang[g] = -1;
      fixed_dly[g] = 0;
    end
    test_reset;
    test_divider;
    test_full_dump(0, 0);
    test_full_dump(0, 1);
    test_full_dump(1, 0);
    test_full_dump(1, 1);
    test_drain;
    test_timeout;
    test_back_to_back;
    test_reset_mid_dump;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
